num2ascii_stream: RTL and testbench

- Parametrised binary-to-decimal-ASCII streamer for the LCD text path.
- Accepts one binary word per request and converts it to BCD internally with a sequential shift-add-3 (double-dabble) engine, one bit per cycle.
- Emits the decimal string most significant character first, with a valid/ready handshake into the LCD character writer.
- Options: leading-zero blanking and signed (two's-complement) display.

---
 rtl/num2ascii_stream_if.sv | 22 ++
 rtl/num2ascii_stream.sv | 125 ++++++++++++
 tb/tb_num2ascii_stream.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/num2ascii_stream_if.sv
// Request/character-stream bundle between a number source, the converter and the LCD writer.
interface num2ascii_stream_if #(
  parameter int unsigned BIN_W = 32
);
  logic             start;
  logic [BIN_W-1:0] bin;
  logic             busy;
  logic [7:0]       char_o;
  logic             valid_o;
  logic             ready_i;
  logic             last_o;

  modport master (
    output start, bin, ready_i,
    input  busy, char_o, valid_o, last_o
  );

  modport slave (
    input  start, bin, ready_i,
    output busy, char_o, valid_o, last_o
  );
endinterface

// File: rtl/num2ascii_stream.sv
// Binary word to decimal ASCII string: sequential double-dabble, then MSD-first
// character emission on a valid/ready stream with optional zero blanking and sign.
module num2ascii_stream #(
  parameter int unsigned BIN_W      = 32,
  parameter int unsigned DIGITS     = 10,
  parameter int unsigned ZERO_BLANK = 1,
  parameter logic [7:0]  PAD_CHAR   = 8'h20,
  parameter int unsigned SIGNED     = 0
) (
  input logic               CLK,
  input logic               RST,
  num2ascii_stream_if.slave bus
);

  localparam int unsigned N     = DIGITS + SIGNED;
  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned CNT_W = $clog2(BIN_W);

  typedef enum logic [1:0] {StIdle, StConv, StEmit} state_e;

  state_e              state_q, state_d;
  logic [BIN_W-1:0]    shreg_q, shreg_d;
  logic [4*DIGITS-1:0] bcd_q, bcd_d, bcd_adj;
  logic                neg_q, neg_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d, dsel;
  logic                conv_done, is_last, accept;
  logic [DIGITS-1:0]   lead_zero;
  logic                zero_run, blank;
  logic [3:0]          nib;

  assign conv_done = (cnt_q == CNT_W'(BIN_W - 1));
  assign is_last   = (idx_q == IDX_W'(N - 1));
  assign accept    = (state_q == StEmit) && bus.ready_i;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state_q <= StIdle;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (bus.start)         state_d = StConv;
      StConv:  if (conv_done)         state_d = StEmit;
      StEmit:  if (accept && is_last) state_d = StIdle;
      default:                        state_d = StIdle;
    endcase
  end

  // Datapath: magnitude capture, one double-dabble step per cycle, char index.
  always_comb begin
    shreg_d = shreg_q;
    bcd_d   = bcd_q;
    neg_d   = neg_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    bcd_adj = bcd_q;
    for (int k = 0; k < int'(DIGITS); k++) begin
      if (bcd_q[4*k +: 4] >= 4'd5) bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
    end
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          neg_d   = (SIGNED != 0) && bus.bin[BIN_W-1];
          shreg_d = neg_d ? (~bus.bin + BIN_W'(1)) : bus.bin;
          bcd_d   = '0;
          cnt_d   = '0;
          idx_d   = '0;
        end
      end
      StConv: begin
        {bcd_d, shreg_d} = {bcd_adj, shreg_q} << 1;
        cnt_d            = cnt_q + CNT_W'(1);
      end
      StEmit: if (accept) idx_d = idx_q + IDX_W'(1);
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      shreg_q <= '0;
      bcd_q   <= '0;
      neg_q   <= 1'b0;
      cnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      shreg_q <= shreg_d;
      bcd_q   <= bcd_d;
      neg_q   <= neg_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    // lead_zero[k]: digit k (0 = most significant) and all above it are zero.
    zero_run  = 1'b1;
    lead_zero = '0;
    for (int k = 0; k < int'(DIGITS); k++) begin
      zero_run     = zero_run && (bcd_q[4*(int'(DIGITS)-1-k) +: 4] == 4'd0);
      lead_zero[k] = zero_run;
    end
    dsel  = idx_q - IDX_W'(SIGNED);
    nib   = 4'd0;
    blank = 1'b0;
    for (int k = 0; k < int'(DIGITS); k++) begin
      if (dsel == IDX_W'(k)) begin
        nib   = bcd_q[4*(int'(DIGITS)-1-k) +: 4];
        blank = lead_zero[k] && (k != int'(DIGITS) - 1);
      end
    end
    bus.busy    = (state_q != StIdle);
    bus.valid_o = (state_q == StEmit);
    bus.last_o  = bus.valid_o && is_last;
    bus.char_o  = 8'h00;
    if (bus.valid_o) begin
      if ((SIGNED != 0) && (idx_q == '0)) bus.char_o = neg_q ? 8'h2D : PAD_CHAR;
      else if ((ZERO_BLANK != 0) && blank) bus.char_o = PAD_CHAR;
      else                                 bus.char_o = 8'h30 + {4'h0, nib};
    end
  end

endmodule

// File: tb/tb_num2ascii_stream.sv
// Bench: three configurations (plain, blanked, signed+blanked) driven in lockstep and
// compared against literal strings and a decimal-arithmetic reference model.
module tb_num2ascii_stream;

  logic        CLK = 1'b0;
  logic        RST;
  logic        start;
  logic [31:0] bin;
  logic        ready = 1'b1;
  int          stall_mode = 0;
  int          ph = 0;
  int          n_cmp = 0;
  int          n_err = 0;
  bit          mon_en = 1'b0;
  string       rx [3];
  bit          held [3];
  logic [7:0]  prev_c [3];
  logic        prev_l [3];
  int          last_cnt [3];
  int          last_pos [3];

  always #5 CLK = ~CLK;

  num2ascii_stream_if #(.BIN_W(32)) if0 ();
  num2ascii_stream_if #(.BIN_W(32)) if1 ();
  num2ascii_stream_if #(.BIN_W(32)) if2 ();

  assign if0.start = start;  assign if0.bin = bin;  assign if0.ready_i = ready;
  assign if1.start = start;  assign if1.bin = bin;  assign if1.ready_i = ready;
  assign if2.start = start;  assign if2.bin = bin;  assign if2.ready_i = ready;

  num2ascii_stream #(.BIN_W(32), .DIGITS(10), .ZERO_BLANK(0), .PAD_CHAR(8'h20), .SIGNED(0))
    u_plain (.CLK(CLK), .RST(RST), .bus(if0));
  num2ascii_stream #(.BIN_W(32), .DIGITS(10), .ZERO_BLANK(1), .PAD_CHAR(8'h20), .SIGNED(0))
    u_blank (.CLK(CLK), .RST(RST), .bus(if1));
  num2ascii_stream #(.BIN_W(32), .DIGITS(10), .ZERO_BLANK(1), .PAD_CHAR(8'h20), .SIGNED(1))
    u_sign (.CLK(CLK), .RST(RST), .bus(if2));

  // Consumer ready: 0 = always, 1 = pattern 1,0,0, 2 = random.
  always @(posedge CLK) begin
    #1;
    ph++;
    case (stall_mode)
      1:       ready = (ph % 3 == 0);
      2:       ready = 1'($urandom_range(0, 1));
      default: ready = 1'b1;
    endcase
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_s(input string name, input string act, input string exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got \"%s\" expected \"%s\" (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic mon(input int g, input logic v, input logic r, input logic [7:0] c,
                     input logic l);
    if (!mon_en) return;
    if (held[g]) begin
      chk($sformatf("stall_valid%0d", g), v, 1);
      chk($sformatf("stall_char%0d", g), c, prev_c[g]);
      chk($sformatf("stall_last%0d", g), l, prev_l[g]);
    end
    held[g]   = v && !r;
    prev_c[g] = c;
    prev_l[g] = l;
    if (v && r) begin
      rx[g] = {rx[g], $sformatf("%c", c)};
      if (l) begin
        last_cnt[g]++;
        last_pos[g] = rx[g].len() - 1;
      end
    end
  endtask

  always @(negedge CLK) mon(0, if0.valid_o, if0.ready_i, if0.char_o, if0.last_o);
  always @(negedge CLK) mon(1, if1.valid_o, if1.ready_i, if1.char_o, if1.last_o);
  always @(negedge CLK) mon(2, if2.valid_o, if2.ready_i, if2.char_o, if2.last_o);

  // Reference: repeated division by ten, then blanking and sign as string edits.
  function automatic string model(input logic [31:0] v, input bit zb, input bit sg);
    longint unsigned mag;
    bit              neg;
    string           s, sgn;
    neg = sg && v[31];
    mag = neg ? (64'h1_0000_0000 - {32'h0, v}) : {32'h0, v};
    s   = "";
    for (int k = 0; k < 10; k++) begin
      s   = {$sformatf("%0d", mag % 10), s};
      mag = mag / 10;
    end
    if (zb) begin
      for (int k = 0; k < 9; k++) begin
        if (s.getc(k) != 8'h30) break;
        s.putc(k, 8'h20);
      end
    end
    if (sg) begin
      sgn = neg ? "-" : " ";
      s   = {sgn, s};
    end
    return s;
  endfunction

  task automatic chk_idle(input string tag);
    chk({tag, "_valid0"}, if0.valid_o, 0); chk({tag, "_busy0"}, if0.busy, 0);
    chk({tag, "_last0"}, if0.last_o, 0);   chk({tag, "_char0"}, if0.char_o, 0);
    chk({tag, "_valid1"}, if1.valid_o, 0); chk({tag, "_busy1"}, if1.busy, 0);
    chk({tag, "_last1"}, if1.last_o, 0);   chk({tag, "_char1"}, if1.char_o, 0);
    chk({tag, "_valid2"}, if2.valid_o, 0); chk({tag, "_busy2"}, if2.busy, 0);
    chk({tag, "_last2"}, if2.last_o, 0);   chk({tag, "_char2"}, if2.char_o, 0);
  endtask

  task automatic clear_rx();
    for (int g = 0; g < 3; g++) begin
      rx[g] = ""; held[g] = 1'b0; last_cnt[g] = 0; last_pos[g] = -1;
    end
  endtask

  task automatic check_out(input int g, input string exp);
    chk_s($sformatf("string%0d", g), rx[g], exp);
    chk($sformatf("last_count%0d", g), last_cnt[g], 1);
    chk($sformatf("last_pos%0d", g), last_pos[g], exp.len() - 1);
  endtask

  task automatic wait_all_idle(input string tag);
    for (int c = 0; c < 3000; c++) begin
      if (!if0.busy && !if1.busy && !if2.busy) break;
      @(negedge CLK);
    end
    chk({tag, "_done"}, {if0.busy, if1.busy, if2.busy}, 0);
  endtask

  // One string per DUT; lat = edges from the start-sampling edge to first valid.
  task automatic run_txn(input logic [31:0] v, input int mode, output int lat, output int emit);
    clear_rx();
    mon_en     = 1'b1;
    stall_mode = mode;
    @(posedge CLK); #1; start = 1'b1; bin = v;
    @(posedge CLK); #1; start = 1'b0;
    lat = 1;
    for (int c = 0; c < 100; c++) begin
      @(negedge CLK);
      if (if0.valid_o) break;
      lat++;
    end
    emit = 0;
    for (int c = 0; c < 3000; c++) begin
      if (if0.valid_o) emit++;
      if (!if0.busy && !if1.busy && !if2.busy) break;
      @(negedge CLK);
    end
    chk("txn_done", {if0.busy, if1.busy, if2.busy}, 0);
  endtask

  typedef struct {
    logic [31:0] v;
    int          mode;
    string       e0;
    string       e1;
    string       e2;
  } vec_t;

  vec_t  tbl [7];
  int    lat, emit;
  logic [31:0] rv;
  string exp_g;

  initial begin
    tbl[0] = '{32'd1234567890, 0, "1234567890", "1234567890", " 1234567890"};
    tbl[1] = '{32'd0,          0, "0000000000", "         0", "          0"};
    tbl[2] = '{32'd42,         0, "0000000042", "        42", "         42"};
    tbl[3] = '{32'hFFFFFFFF,   0, "4294967295", "4294967295", "-         1"};
    tbl[4] = '{32'h80000000,   0, "2147483648", "2147483648", "-2147483648"};
    tbl[5] = '{32'd5,          0, "0000000005", "         5", "          5"};
    tbl[6] = '{32'd42,         1, "0000000042", "        42", "         42"};

    RST = 1'b0; start = 1'b0; bin = '0;
    #3;
    chk_idle("reset");
    @(negedge CLK);
    RST = 1'b1;

    for (int i = 0; i < 7; i++) begin
      run_txn(tbl[i].v, tbl[i].mode, lat, emit);
      chk($sformatf("latency_v%0d", i), lat, 33);
      if (tbl[i].mode == 0) chk($sformatf("emit_cycles_v%0d", i), emit, 10);
      check_out(0, tbl[i].e0);
      check_out(1, tbl[i].e1);
      check_out(2, tbl[i].e2);
      for (int g = 0; g < 3; g++) begin
        exp_g = model(tbl[i].v, g != 0, g == 2);
        chk_s($sformatf("model%0d_v%0d", g, i), rx[g], exp_g);
      end
    end

    // Starts during CONV and EMIT are ignored; a start right after the last accept is taken.
    clear_rx();
    mon_en = 1'b1; stall_mode = 0;
    @(posedge CLK); #1; start = 1'b1; bin = 32'hFFFFFFFF;
    @(posedge CLK); #1; start = 1'b0;
    repeat (10) @(posedge CLK);
    #1; start = 1'b1; bin = 32'd7;
    @(posedge CLK); #1; start = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge CLK);
      if (if0.valid_o) break;
    end
    @(posedge CLK); #1; start = 1'b1;
    @(posedge CLK); #1; start = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge CLK);
      if (if0.valid_o && if0.last_o) break;
    end
    @(posedge CLK); #1;
    chk("busy_after_last", if0.busy, 0);
    check_out(0, "4294967295");
    check_out(1, "4294967295");
    for (int g = 0; g < 2; g++) begin
      rx[g] = ""; last_cnt[g] = 0; last_pos[g] = -1;
    end
    start = 1'b1;
    @(posedge CLK); #1; start = 1'b0;
    wait_all_idle("restart");
    check_out(0, "0000000007");
    check_out(1, "         7");
    check_out(2, "-         1");

    // Asynchronous reset in the middle of emission.
    clear_rx();
    mon_en = 1'b1; stall_mode = 0;
    @(posedge CLK); #1; start = 1'b1; bin = 32'd123456;
    @(posedge CLK); #1; start = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge CLK);
      if (if0.valid_o) break;
    end
    repeat (3) @(posedge CLK);
    #2; mon_en = 1'b0;
    #1; RST = 1'b0;
    #1;
    chk_idle("mid_emit_reset");
    chk_s("pre_reset_chars", rx[0], "000");
    #5; RST = 1'b1;
    @(negedge CLK);
    run_txn(32'd99, 0, lat, emit);
    chk("latency_after_reset", lat, 33);
    check_out(0, "0000000099");
    check_out(1, "        99");
    check_out(2, "         99");

    // Randomized values and consumer stalls against the reference model.
    for (int i = 0; i < 24; i++) begin
      case ($urandom_range(0, 3))
        0:       rv = $urandom;
        1:       rv = $urandom_range(0, 999);
        2:       rv = {1'b1, 31'($urandom)};
        default: rv = 32'd0 - $urandom_range(1, 1000);
      endcase
      run_txn(rv, 2, lat, emit);
      chk($sformatf("rand_latency%0d", i), lat, 33);
      for (int g = 0; g < 3; g++) begin
        exp_g = model(rv, g != 0, g == 2);
        check_out(g, exp_g);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
